// File: rtl/switch_debouncer.sv
// switch_debouncer: synchronizes a raw bouncing switch and commits a clean level
// after STABLE_CYCLES consecutive agreeing samples. Also emits registered
// rise/fall pulses and a saturating count of aborted transitions.
module switch_debouncer #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned GLITCH_W      = 8
) (
  input  logic                input_clock1_1,
  input  logic                input_reset2_2,
  input  logic                input_switch3_3,
  output logic                output_level_0_4,
  output logic                output_rise_0_5,
  output logic                output_fall_0_6,
  output logic [GLITCH_W-1:0] output_glitch_0_7
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
  localparam logic [GLITCH_W-1:0] GLITCH_MAX = '1;

  typedef enum logic [1:0] {
    IDLE_LOW   = 2'd0,
    CHECK_HIGH = 2'd1,
    IDLE_HIGH  = 2'd2,
    CHECK_LOW  = 2'd3
  } state_e;

  logic                sync1_q;
  logic                s_q;
  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                level_q;
  logic                rise_q;
  logic                fall_q;
  logic [GLITCH_W-1:0] glitch_q;

  // Saturating increment value for the glitch counter.
  logic [GLITCH_W-1:0] glitch_inc_c;
  assign glitch_inc_c = (glitch_q == GLITCH_MAX) ? glitch_q : glitch_q + GLITCH_W'(1);

  // Two-flop synchronizer; the FSM only ever looks at s_q.
  always_ff @(posedge input_clock1_1) begin
    if (input_reset2_2) begin
      sync1_q <= 1'b0;
      s_q     <= 1'b0;
    end else begin
      sync1_q <= input_switch3_3;
      s_q     <= sync1_q;
    end
  end

  // Debounce FSM: level, pulses and glitch count are all registered here.
  always_ff @(posedge input_clock1_1) begin
    if (input_reset2_2) begin
      state_q  <= IDLE_LOW;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      unique case (state_q)
        IDLE_LOW: begin
          if (s_q) begin
            state_q <= CHECK_HIGH;
            cnt_q   <= CNT_ONE;
          end
        end
        CHECK_HIGH: begin
          if (!s_q) begin
            state_q  <= IDLE_LOW;
            glitch_q <= glitch_inc_c;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE_HIGH;
            level_q <= 1'b1;
            rise_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        IDLE_HIGH: begin
          if (!s_q) begin
            state_q <= CHECK_LOW;
            cnt_q   <= CNT_ONE;
          end
        end
        CHECK_LOW: begin
          if (s_q) begin
            state_q  <= IDLE_HIGH;
            glitch_q <= glitch_inc_c;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE_LOW;
            level_q <= 1'b0;
            fall_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: state_q <= IDLE_LOW;
      endcase
    end
  end

  assign output_level_0_4  = level_q;
  assign output_rise_0_5   = rise_q;
  assign output_fall_0_6   = fall_q;
  assign output_glitch_0_7 = glitch_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: three parameterizations share one switch input and
// are compared every cycle against a run-length reference model. A D flip-flop
// stands in for the downstream stage fed by the debounced level.
module tb_switch_debouncer;

  localparam int unsigned N = 3;
  localparam int unsigned SC   [N] = '{4, 4, 2};
  localparam int unsigned GMAX [N] = '{255, 3, 15};

  logic clk;
  logic rst;
  logic sw;

  logic       lvl_o  [N];
  logic       rise_o [N];
  logic       fall_o [N];
  logic [7:0] glitch_a;
  logic [1:0] glitch_b;
  logic [3:0] glitch_c;

  int unsigned n_cmp;
  int unsigned n_bad;

  // Reference model state
  int unsigned m_lvl  [N];
  int unsigned m_run  [N];
  int unsigned m_gl   [N];
  int unsigned m_rise [N];
  int unsigned m_fall [N];
  int unsigned m_sync1;
  int unsigned m_s;
  int unsigned m_dff;
  bit          dff_chk;

  logic dff_q;
  logic dff_qn;

  switch_debouncer #(.STABLE_CYCLES(4), .GLITCH_W(8)) u_a (
    .input_clock1_1(clk), .input_reset2_2(rst), .input_switch3_3(sw),
    .output_level_0_4(lvl_o[0]), .output_rise_0_5(rise_o[0]),
    .output_fall_0_6(fall_o[0]), .output_glitch_0_7(glitch_a));

  switch_debouncer #(.STABLE_CYCLES(4), .GLITCH_W(2)) u_b (
    .input_clock1_1(clk), .input_reset2_2(rst), .input_switch3_3(sw),
    .output_level_0_4(lvl_o[1]), .output_rise_0_5(rise_o[1]),
    .output_fall_0_6(fall_o[1]), .output_glitch_0_7(glitch_b));

  switch_debouncer #(.STABLE_CYCLES(2), .GLITCH_W(4)) u_c (
    .input_clock1_1(clk), .input_reset2_2(rst), .input_switch3_3(sw),
    .output_level_0_4(lvl_o[2]), .output_rise_0_5(rise_o[2]),
    .output_fall_0_6(fall_o[2]), .output_glitch_0_7(glitch_c));

  // Downstream D flip-flop driven by the default-configured debouncer.
  always_ff @(posedge clk) begin
    dff_q  <= lvl_o[0];
    dff_qn <= ~lvl_o[0];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned glitch_of(input int i);
    case (i)
      0:       return 32'(glitch_a);
      1:       return 32'(glitch_b);
      default: return 32'(glitch_c);
    endcase
  endfunction

  // Model: level flips once s has differed from it on STABLE consecutive edges;
  // a run that ends early counts one glitch.
  task automatic model_step(input logic r, input logic swv);
    m_dff = m_lvl[0];
    for (int i = 0; i < int'(N); i++) begin
      m_rise[i] = 0;
      m_fall[i] = 0;
      if (r) begin
        m_lvl[i] = 0;
        m_run[i] = 0;
        m_gl[i]  = 0;
      end else if (m_s != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == SC[i]) begin
          m_lvl[i]  = m_s;
          m_rise[i] = m_s;
          m_fall[i] = 1 - m_s;
          m_run[i]  = 0;
        end
      end else if (m_run[i] != 0) begin
        if (m_gl[i] < GMAX[i]) m_gl[i]++;
        m_run[i] = 0;
      end
    end
    if (r) begin
      m_s     = 0;
      m_sync1 = 0;
    end else begin
      m_s     = m_sync1;
      m_sync1 = 32'(swv);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < int'(N); i++) begin
      check_eq($sformatf("level%0d", i), 32'(lvl_o[i]), m_lvl[i]);
      check_eq($sformatf("rise%0d", i), 32'(rise_o[i]), m_rise[i]);
      check_eq($sformatf("fall%0d", i), 32'(fall_o[i]), m_fall[i]);
      check_eq($sformatf("glitch%0d", i), glitch_of(i), m_gl[i]);
    end
    if (dff_chk) begin
      check_eq("dff_q", 32'(dff_q), m_dff);
      check_eq("dff_qn", 32'(dff_qn), 1 - m_dff);
    end
  endtask

  task automatic cycle(input logic r, input logic swv);
    @(negedge clk);
    rst = r;
    sw  = swv;
    @(posedge clk);
    model_step(r, swv);
    #1;
    compare_all();
  endtask

  task automatic hold(input logic swv, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) cycle(1'b0, swv);
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    rst     = 1'b1;
    sw      = 1'b0;
    dff_chk = 1'b0;
    m_sync1 = 0;
    m_s     = 0;
    m_dff   = 0;
    for (int i = 0; i < int'(N); i++) begin
      m_lvl[i] = 0; m_run[i] = 0; m_gl[i] = 0; m_rise[i] = 0; m_fall[i] = 0;
    end

    // Reset, then quiet low input
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    dff_chk = 1'b1;
    hold(1'b0, 20);

    // Clean press and release
    hold(1'b1, 15);
    hold(1'b0, 15);

    // Bouncing press and bouncing release
    hold(1'b1, 2); hold(1'b0, 2); hold(1'b1, 2); hold(1'b0, 2);
    hold(1'b1, 12);
    hold(1'b0, 2); hold(1'b1, 2); hold(1'b0, 2); hold(1'b1, 2);
    hold(1'b0, 12);

    // Reset while a rising transition is being checked
    hold(1'b1, 4);
    cycle(1'b1, 1'b1);
    hold(1'b1, 10);
    hold(1'b0, 12);

    // Glitch saturation with short pulses from a settled low level
    for (int p = 0; p < 6; p++) begin
      hold(1'b1, 3);
      hold(1'b0, 7);
    end
    check_eq("sat_glitch_a", 32'(glitch_a), 6);
    check_eq("sat_glitch_b", 32'(glitch_b), 3);
    check_eq("sat_level_a", 32'(lvl_o[0]), 0);
    check_eq("sat_level_b", 32'(lvl_o[1]), 0);

    // Randomized bouncing with occasional resets
    begin
      logic v;
      v = 1'b0;
      for (int n = 0; n < 300; n++) begin
        int unsigned len;
        v   = ~v;
        len = $urandom_range(1, 9);
        for (int unsigned k = 0; k < len; k++)
          cycle(($urandom_range(0, 299) == 0), v);
      end
    end
    hold(1'b1, 12);
    hold(1'b0, 12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
